// File: rtl/mux_nto1_rr.sv
// N-channel DW-bit selector with a registered valid/ready output stage.
// Channel choice is either a fixed index (mode=0) or round-robin from ptr (mode=1).
module mux_nto1_rr_lane #(
  parameter int DW  = 8,
  parameter int SW  = 2,
  parameter int IDX = 0
) (
  input  logic [SW-1:0] pick_i,
  input  logic          en_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic [DW-1:0] data_o
);
  assign ready_o = en_i && (pick_i == SW'(IDX));
  // Gated data lets the top build the mux as a plain OR tree.
  assign data_o  = (pick_i == SW'(IDX)) ? data_i : '0;
endmodule

module mux_nto1_rr #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int SW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N*DW-1:0] in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   grant_idx
);
  logic [DW-1:0]         out_data_q;
  logic                  out_valid_q;
  logic [SW-1:0]         grant_q;
  logic [SW-1:0]         ptr_q, ptr_d;
  logic [SW-1:0]         pick;
  logic                  pick_valid;
  logic                  load_ok;
  logic                  xfer;
  logic [N-1:0][DW-1:0]  lane_data;
  logic [DW-1:0]         pick_data;

  assign load_ok = !out_valid_q || out_ready;
  // Reset cycle must not hand out a ready: the word would be lost.
  assign xfer    = !rst && load_ok && pick_valid;

  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    if (!mode) begin
      // An out-of-range sel matches no channel, so no pick is made.
      for (int i = 0; i < N; i++)
        if (SW'(i) == sel) begin
          pick       = sel;
          pick_valid = in_valid[i];
        end
    end else begin
      // Walk backwards so the channel closest to ptr wins.
      for (int k = N-1; k >= 0; k--) begin
        if (in_valid[(int'(ptr_q) + k) % N]) begin
          pick       = SW'((int'(ptr_q) + k) % N);
          pick_valid = 1'b1;
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_lane
      mux_nto1_rr_lane #(.DW(DW), .SW(SW), .IDX(g)) u_lane (
        .pick_i  (pick),
        .en_i    (xfer),
        .data_i  (in_data[g*DW +: DW]),
        .ready_o (in_ready[g]),
        .data_o  (lane_data[g])
      );
    end
  endgenerate

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N; i++) pick_data = pick_data | lane_data[i];
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer && mode) ptr_d = (pick == SW'(N-1)) ? '0 : pick + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      ptr_q       <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (xfer) begin
        out_data_q  <= pick_data;
        out_valid_q <= 1'b1;
        grant_q     <= pick;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign grant_idx = grant_q;
endmodule

// File: doc/mux_nto1_rr.md
Name: mux_nto1_rr

Overview:
- Parametrised N-channel, DW-bit selector. Successor to the team's combinational 2:1 mux family.
- Adds a registered output stage with valid/ready handshake and two selection modes: fixed select or round-robin arbitration.
- Sits between multiple producer channels and a single consumer stage in the Practice datapath.

Parameters:
N, 4, number of input channels (2..16)
DW, 8, data width per channel
SW, 2, select/index width; must equal ceil(log2(N))

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
mode  input  1  0 = fixed select by sel, 1 = round-robin
sel  input  SW  channel index used when mode=0
in_data  input  N*DW  channel i occupies bits [i*DW +: DW]
in_valid  input  N  per-channel valid
in_ready  output  N  per-channel ready, combinational
out_data  output  DW  registered data
out_valid  output  1  registered valid
out_ready  input  1  consumer ready
grant_idx  output  SW  registered index of the channel that supplied out_data

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset values (sampled high on a clk edge):
  - out_valid=0, out_data=0, grant_idx=0.
  - Internal round-robin pointer ptr=0.
  - Any held word is dropped, including mid-transfer; no in_ready asserts in that cycle.
- load_ok = !out_valid || out_ready. The output register accepts a new word only when load_ok=1.
- Pick logic (combinational):
  - mode=0: pick=sel; pick_valid = in_valid[sel] && (sel < N). If sel >= N, no pick is made.
  - mode=1: scan channels ptr, ptr+1, ..., wrapping modulo N. pick = first i with in_valid[i]=1; pick_valid=1 if any in_valid is set.
- in_ready[i] = load_ok && pick_valid && (pick==i).
  - At most one bit of in_ready is set (one-hot or zero).
  - in_ready may depend on in_valid. Producers must not make in_valid depend on in_ready.
- Transfer on channel i when in_valid[i] && in_ready[i]. At the next edge:
  - out_data <= channel i data; out_valid <= 1; grant_idx <= i.
  - If mode=1: ptr <= (i+1) mod N. If mode=0: ptr is unchanged.
- No transfer but out_valid && out_ready: out_valid <= 0. out_data and grant_idx hold their last values.
- Back-pressure: out_valid && !out_ready holds out_data and grant_idx stable, and all in_ready bits are 0.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 word/cycle when out_ready is held high.
- Consume and load in the same cycle: out_valid stays 1 and the new word replaces the old one. No bubble.
- Changing mode or sel while a word is held does not alter out_data or grant_idx.
- Round-robin pointer wraps: after a grant to N-1, ptr=0.
- Fairness: with all channels valid and out_ready=1 in mode=1, grants cycle 0,1,...,N-1,0. Every active channel is served within N grants.

Test Plan:
- Reset: drive rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, grant_idx=0, in_ready=0 during reset. After release with mode=1, the first grant goes to channel 0.
- Fixed mode: mode=0, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=8'hA5, grant_idx=2. With sel=1 and in_valid=4'b0100 -> in_ready=0, and out_valid drops the cycle after consumption.
- Round-robin fairness: mode=1, in_valid=4'b1111, channel data = 8'h10,8'h11,8'h12,8'h13, out_ready=1 for 8 cycles -> grant_idx sequence 0,1,2,3,0,1,2,3; out_valid stays 1 throughout.
- Sparse round-robin and wrap: mode=1, in_valid=4'b1001 -> grants alternate 0,3,0,3; ptr wraps from 3 to 0.
- Back-pressure: out_valid=1 holding 8'h11, out_ready=0 for 3 cycles with in_valid=4'b1111 -> out_data and grant_idx stable, in_ready=0. Raise out_ready -> the next word loads in the same cycle with no bubble.
- Reset mid-operation: out_valid=1 with out_ready=0, assert rst for 1 cycle -> out_valid=0, out_data=0, ptr=0. The held word is never presented.
